// File: rtl/dct_job_arb.sv
// rtl/dct_job_arb.sv - round-robin job arbiter sharing one 2-D DCT/IDCT engine between encoder and decoder paths
module dct_job_arb #(
    parameter int D_WIDTH = 13,
    parameter int OUT_CNT = 64,
    parameter int TIMEOUT = 1023
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               req0,
    input  logic               req1,
    output logic               gnt0,
    output logic               gnt1,
    input  logic               in0_en,
    input  logic [6:0]         in0_idx,
    input  logic [D_WIDTH-1:0] in0_data,
    input  logic               in1_en,
    input  logic [6:0]         in1_idx,
    input  logic [D_WIDTH-1:0] in1_data,
    output logic               dct_flag,
    output logic               rm_data_en,
    output logic [6:0]         rm_data_idx,
    output logic [D_WIDTH-1:0] rm_data,
    input  logic               dct_out_en,
    output logic               done0,
    output logic               done1,
    output logic               err,
    output logic               busy
);

    localparam logic [7:0] OUT_CNT_W = 8'(OUT_CNT);
    localparam logic [9:0] TIMEOUT_W = 10'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t               state;
    logic                 last_gnt;
    logic                 last_fwd;
    logic [6:0]           out_cnt;
    logic [9:0]           timer;

    logic                 sel_en;
    logic [6:0]           sel_idx;
    logic [D_WIDTH-1:0]   sel_data;
    logic [2:0]           last_row;
    logic [7:0]           cnt_next;
    logic                 win1;

    always_comb begin
        sel_en   = gnt1 ? in1_en   : in0_en;
        sel_idx  = gnt1 ? in1_idx  : in0_idx;
        sel_data = gnt1 ? in1_data : in0_data;
        last_row = dct_flag ? 3'd4 : 3'd7;
        cnt_next = {1'b0, out_cnt} + {7'b0, dct_out_en};
        // requester 1 wins on a tie only when requester 0 was served last
        win1     = req1 && (!req0 || !last_gnt);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_gnt    <= 1'b1;
            last_fwd    <= 1'b0;
            out_cnt     <= '0;
            timer       <= '0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            dct_flag    <= 1'b0;
            rm_data_en  <= 1'b0;
            rm_data_idx <= '0;
            rm_data     <= '0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    out_cnt    <= '0;
                    timer      <= '0;
                    last_fwd   <= 1'b0;
                    rm_data_en <= 1'b0;
                    if (req0 || req1) begin
                        gnt0     <= !win1;
                        gnt1     <= win1;
                        dct_flag <= !win1;
                        last_gnt <= win1;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    // engine outputs may begin before the block has fully loaded
                    if (dct_out_en && out_cnt != 7'h7F) begin
                        out_cnt <= out_cnt + 7'd1;
                    end
                    if (last_fwd) begin
                        rm_data_en <= 1'b0;
                        last_fwd   <= 1'b0;
                        timer      <= '0;
                        state      <= DRAIN;
                    end else begin
                        rm_data_en  <= sel_en;
                        rm_data_idx <= sel_idx;
                        rm_data     <= sel_data;
                        last_fwd    <= sel_en && (sel_idx == {last_row, 4'd14});
                    end
                end
                DRAIN: begin
                    rm_data_en <= 1'b0;
                    if (cnt_next >= OUT_CNT_W || timer == TIMEOUT_W) begin
                        done0   <= gnt0 && (cnt_next >= OUT_CNT_W);
                        done1   <= gnt1 && (cnt_next >= OUT_CNT_W);
                        err     <= (cnt_next < OUT_CNT_W);
                        gnt0    <= 1'b0;
                        gnt1    <= 1'b0;
                        out_cnt <= '0;
                        timer   <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        timer   <= timer + 10'd1;
                        out_cnt <= cnt_next[6:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
